// File: rtl/ysyx_23060077_ifu_pkg.sv
// Shared definitions for the ysyx_23060077 instruction fetch unit.
// Holds FSM state encodings, AXI response codes and the reset PC default.
package ysyx_23060077_ifu_pkg;

  typedef enum logic [1:0] {
    IFU_AR  = 2'd0,
    IFU_R   = 2'd1,
    IFU_OUT = 2'd2
  } ifu_state_e;

  localparam logic [1:0]  AXI_RESP_OKAY    = 2'b00;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h3000_0000;

  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_23060077_ifu.sv
// Fetch stage: one AXI4-Lite read per instruction, valid/ready hand-off to decode, redirect flush.
// Optional YSYX_23060077_IFU_MISALIGN_CHK_EN: misaligned redirect targets fault without a bus read.
module ysyx_23060077_ifu
  import ysyx_23060077_ifu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [INST_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  access_fault
);

`ifdef YSYX_23060077_IFU_MISALIGN_CHK_EN
  localparam bit MisalignChk = 1'b1;
`else
  localparam bit MisalignChk = 1'b0;
`endif

  ifu_state_e            state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pend_pc_q;
  logic                  flush_q;
  logic [INST_WIDTH-1:0] inst_q;
  logic [ADDR_WIDTH-1:0] inst_pc_q;
  logic                  fault_q;

  // A redirect in the current cycle overrides any target parked during a flush.
  logic [ADDR_WIDTH-1:0] tgt_pc;
  logic                  tgt_bad;

  assign tgt_pc  = redirect_valid ? redirect_pc : pend_pc_q;
  assign tgt_bad = MisalignChk && is_misaligned(tgt_pc[1:0]);

  assign arvalid      = (state_q == IFU_AR);
  assign araddr       = pc_q;
  assign rready       = (state_q == IFU_R);
  assign inst_valid   = (state_q == IFU_OUT) & ~redirect_valid;
  assign inst         = inst_q;
  assign inst_pc      = inst_pc_q;
  assign access_fault = fault_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IFU_AR;
      pc_q      <= RESET_PC;
      pend_pc_q <= RESET_PC;
      flush_q   <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IFU_AR: begin
          // Address stays on the old PC until accepted; the reply is dropped later.
          if (redirect_valid) begin
            flush_q   <= 1'b1;
            pend_pc_q <= redirect_pc;
          end
          if (arready) begin
            state_q <= IFU_R;
          end
        end

        IFU_R: begin
          if (rvalid) begin
            if (flush_q || redirect_valid) begin
              flush_q <= 1'b0;
              pc_q    <= tgt_pc;
              if (tgt_bad) begin
                state_q   <= IFU_OUT;
                inst_q    <= '0;
                inst_pc_q <= tgt_pc;
                fault_q   <= 1'b1;
              end else begin
                state_q <= IFU_AR;
              end
            end else begin
              state_q   <= IFU_OUT;
              inst_q    <= rdata;
              inst_pc_q <= pc_q;
              fault_q   <= (rresp != AXI_RESP_OKAY);
            end
          end else if (redirect_valid) begin
            flush_q   <= 1'b1;
            pend_pc_q <= redirect_pc;
          end
        end

        IFU_OUT: begin
          if (redirect_valid) begin
            pc_q <= redirect_pc;
            if (tgt_bad) begin
              state_q   <= IFU_OUT;
              inst_q    <= '0;
              inst_pc_q <= redirect_pc;
              fault_q   <= 1'b1;
            end else begin
              state_q <= IFU_AR;
            end
          end else if (inst_ready) begin
            pc_q    <= pc_q + ADDR_WIDTH'(4);
            state_q <= IFU_AR;
          end
        end

        default: begin
          state_q <= IFU_AR;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ysyx_23060077_ifu.md
Name: ysyx_23060077_ifu

Overview:
- Instruction fetch stage, directly upstream of the decode stage.
- Holds the PC and issues one AXI4-Lite read per instruction to the instruction bus.
- Presents the fetched 32-bit instruction and its PC to decode over a valid/ready handshake.
- Accepts redirects (jump/branch/trap target) from later stages and discards any wrong-path fetch.

Parameters:
- RESET_PC, 32'h3000_0000, PC value loaded on reset.
- ADDR_WIDTH, 32, bus address and PC width.
- INST_WIDTH, 32, instruction width; equals bus data width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- redirect_valid  in  1  pulse: next fetch must come from redirect_pc
- redirect_pc  in  ADDR_WIDTH  redirect target
- arvalid  out  1  AXI read-address valid
- arready  in  1  AXI read-address ready
- araddr  out  ADDR_WIDTH  fetch address
- rvalid  in  1  AXI read-data valid
- rready  out  1  AXI read-data ready
- rdata  in  INST_WIDTH  read data
- rresp  in  2  read response (2'b00 = OKAY)
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode accepts the instruction
- inst  out  INST_WIDTH  fetched instruction
- inst_pc  out  ADDR_WIDTH  PC of inst
- access_fault  out  1  rresp was not OKAY for this inst

Behaviour:
- One clock domain. Reset is synchronous and active-high, using ports clock and reset.
- FSM states: AR, R, OUT. Reset sets:
  - state = AR, pc = RESET_PC, flush = 0
  - inst = 0, inst_pc = 0, access_fault = 0
- arvalid = (state==AR); araddr = pc (registered, not from redirect_pc).
- rready = (state==R).
- inst_valid = (state==OUT) & ~redirect_valid. The combinational gate guarantees a wrong-path inst is never accepted.
- In AR:
  - arready → R.
  - araddr and arvalid stay stable until the handshake, per AXI.
  - A redirect in AR sets flush = 1 and pending pc = redirect_pc. The address handshake still completes with the old address.
- In R, on rvalid:
  - If flush or redirect_valid: discard data, pc = latest redirect target, flush = 0, → AR.
  - Else: latch inst = rdata, inst_pc = pc, access_fault = (rresp != 0), → OUT.
- In OUT:
  - redirect_valid: drop the held inst, pc = redirect_pc, → AR. This has priority over inst_ready.
  - Else if inst_ready: pc = pc + 4 (wraps modulo 2^32), → AR.
  - Else hold: inst, inst_pc and access_fault stay stable.
- Multiple redirects before drain: the last one wins.
- At most one outstanding read. Minimum fetch-to-fetch spacing is 3 cycles (AR, R, OUT each at least 1 cycle).
- Reset asserted in any state, including R with a read outstanding, returns to the reset values next cycle. A late rvalid in AR is ignored because rready = 0.

Optional Feature:
- Macro: YSYX_23060077_IFU_MISALIGN_CHK_EN
- Defined:
  - A redirect_pc with bits [1:0] != 0 is not fetched.
  - The FSM goes straight to OUT with inst = 0, inst_pc = redirect_pc, access_fault = 1. No bus transaction is issued.
- Undefined: no check; the low bits are passed on araddr unchanged.

Decomposition:
- Shared define file gets:
  - IFU state encodings (AR = 2'd0, R = 2'd1, OUT = 2'd2)
  - AXI_RESP_OKAY = 2'b00
  - RESET_PC default
- Existing INST_WIDTH/DATA_WIDTH macros are reused.
- Sub-module: none needed. The PC register plus flush/pending logic stays inline; the FSM is small.

Test Plan:
- Reset release, arready=1, rvalid after 1 cycle, rdata=32'h0000_0513, inst_ready=1:
  - araddr = 3000_0000
  - inst_valid with inst_pc = 3000_0000
  - next araddr = 3000_0004
- inst_ready held low 5 cycles in OUT: inst, inst_pc and access_fault unchanged; inst_valid stays 1; no arvalid.
- redirect_valid with redirect_pc = 3000_0100 while in R, rvalid 3 cycles later:
  - that rdata is discarded (no inst_valid)
  - next araddr = 3000_0100
- Redirect to 3000_0200 in AR with arready low 2 cycles:
  - araddr stays at the old pc until the handshake
  - the response is discarded
  - next fetch goes to 3000_0200
- rresp = 2'b10: inst_valid with access_fault = 1, inst = rdata.
- Reset asserted mid-R: state returns to AR and araddr = 3000_0000 next cycle. With the macro defined, redirect_pc = 3000_0002 → access_fault = 1 and no arvalid.
